// File: rtl/conf_frame_loader_if.sv
// conf_frame_loader_if: valid/ready byte stream feeding the configuration loader
interface conf_frame_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  modport master (output byte_valid, byte_data, input byte_ready);
  modport slave  (input byte_valid, byte_data, output byte_ready);
endinterface

// File: rtl/conf_frame_loader.sv
// conf_frame_loader: validates framed config bytes and drives the request/confirm handshake
module conf_frame_loader #(
  parameter int         CONFIRM_GAP = 4,
  parameter int         TIMEOUT     = 1000,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 arst,
  conf_frame_loader_if.slave   bs,
  output logic [34:0]          confdata,
  output logic [1:0]           password,
  output logic                 request,
  output logic                 confirm,
  output logic                 frame_err,
  output logic [7:0]           err_count
);
  localparam int MX = TIMEOUT > CONFIRM_GAP ? TIMEOUT : CONFIRM_GAP;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, PAYLOAD, CHECK, REQ, GAP, CONF} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [39:0]   stage_q, stage_d;
  logic [34:0]   conf_q, conf_d;
  logic [1:0]    pw_q, pw_d;
  logic          req_q, req_d, cnf_q, cnf_d, ferr_q, ferr_d, ready_q, ready_d;
  logic [7:0]    errc_q, errc_d;
  logic          acc, err, tmo;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    stage_d = stage_q;
    conf_d  = conf_q;
    pw_d    = pw_q;
    err     = 1'b0;
    acc     = bs.byte_valid & ready_q;
    tmo     = cnt_q == CW'(TIMEOUT - 1);
    case (state_q)
      IDLE: if (acc && bs.byte_data == HEADER) begin
        state_d = PAYLOAD;
        idx_d   = '0;
        xor_d   = '0;
        stage_d = '0;
        cnt_d   = '0;
      end
      PAYLOAD: if (acc) begin
        stage_d[{idx_q, 3'b000} +: 8] = bs.byte_data;
        xor_d   = xor_q ^ bs.byte_data;
        idx_d   = idx_q + 3'd1;
        cnt_d   = '0;
        state_d = idx_q == 3'd4 ? CHECK : PAYLOAD;
      end else if (tmo) err = 1'b1;
      else cnt_d = cnt_q + 1'b1;
      CHECK: if (acc) begin
        cnt_d = '0;
        if (bs.byte_data == xor_q && stage_q[39:37] == 3'b000) begin
          conf_d  = stage_q[34:0];
          pw_d    = stage_q[36:35];
          state_d = REQ;
        end else err = 1'b1;
      end else if (tmo) err = 1'b1;
      else cnt_d = cnt_q + 1'b1;
      REQ: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        state_d = cnt_q == CW'(CONFIRM_GAP - 1) ? CONF : GAP;
        cnt_d   = cnt_q == CW'(CONFIRM_GAP - 1) ? '0 : cnt_q + 1'b1;
      end
      CONF:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (err) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      xor_d   = '0;
      stage_d = '0;
    end
    ferr_d  = err;
    errc_d  = err && errc_q != 8'hFF ? errc_q + 8'd1 : errc_q;
    req_d   = state_d == REQ;
    cnf_d   = state_d == CONF;
    ready_d = state_d == IDLE || state_d == PAYLOAD || state_d == CHECK;
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
      stage_q <= '0;
      conf_q  <= '0;
      pw_q    <= '0;
      req_q   <= 1'b0;
      cnf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      errc_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      stage_q <= stage_d;
      conf_q  <= conf_d;
      pw_q    <= pw_d;
      req_q   <= req_d;
      cnf_q   <= cnf_d;
      ferr_q  <= ferr_d;
      errc_q  <= errc_d;
      ready_q <= ready_d;
    end
  assign bs.byte_ready = ready_q;
  assign confdata      = conf_q;
  assign password      = pw_q;
  assign request       = req_q;
  assign confirm       = cnf_q;
  assign frame_err     = ferr_q;
  assign err_count     = errc_q;
endmodule

// File: doc/conf_frame_loader.md
# conf_frame_loader

Byte-stream configuration front end placed directly upstream of the smart-home top level. It accepts framed configuration bytes over a valid/ready byte interface, checks header, reserved bits and checksum, and assembles the 35-bit `confdata` word and 2-bit `password`. On each good frame it drives the `request` → `confirm` sequence that the control unit expects. Bad or stalled frames are discarded, flagged and counted; they never disturb the last good configuration.

## Interface

Parameters:
- `CONFIRM_GAP`, default 4: idle cycles between the `request` pulse and the `confirm` pulse. Minimum 1.
- `TIMEOUT`, default 1000: maximum cycles allowed between accepted bytes inside a frame.
- `HEADER`, default 8'hA5: start-of-frame byte.

Ports:
- `clk` in 1: clock; all logic is posedge.
- `arst` in 1: reset, asynchronous and active-high.
- `byte_valid` in 1: the upstream source has a byte on `byte_data`.
- `byte_data` in 8: byte value.
- `byte_ready` out 1: the block can accept a byte this cycle.
- `confdata` out 35: configuration word from the last good frame.
- `password` out 2: password from the last good frame.
- `request` out 1: one-cycle pulse to the control unit.
- `confirm` out 1: one-cycle pulse to the control unit.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.
- `err_count` out 8: count of rejected frames; saturates at 255.

## Operation

- A byte is accepted in any cycle where `byte_valid & byte_ready` is 1.
- Frame layout, 7 bytes: `HEADER`, then payload bytes P0..P4, then checksum C.
  - The 40-bit payload is assembled little-endian: P0 = bits[7:0], P4 = bits[39:32].
  - `confdata` = bits[34:0]; `password` = bits[36:35]; bits[39:37] are reserved and must be 0.
  - C must equal P0^P1^P2^P3^P4.
- Payload bytes go into a staging register. `confdata` and `password` update only on a good frame.
- State machine:
  - IDLE: `byte_ready`=1. An accepted byte equal to `HEADER` → PAYLOAD with index 0. Any other accepted byte is dropped silently; no error is raised.
  - PAYLOAD: `byte_ready`=1. Each accepted byte is stored at the current index, and the running XOR is updated. Accepting the byte at index 4 → CHECK. A byte equal to `HEADER` is treated as ordinary data.
  - CHECK: `byte_ready`=1. On an accepted byte:
    - If it matches the checksum and the reserved bits are 0: copy staging to outputs, go to REQ.
    - Otherwise: pulse `frame_err`, increment `err_count`, go to IDLE.
  - REQ: `byte_ready`=0, `request`=1 for this one cycle → GAP.
  - GAP: `byte_ready`=0 for `CONFIRM_GAP` cycles → CONF.
  - CONF: `byte_ready`=0, `confirm`=1 for this one cycle → IDLE.
- Timeout (PAYLOAD and CHECK only):
  - The idle counter clears on every accepted byte.
  - If it reaches `TIMEOUT` with no byte accepted: pulse `frame_err`, increment `err_count`, go to IDLE, discard staging.
- The checksum-error and timeout-error conditions cannot fire in the same cycle. Only one `err_count` increment is made per rejected frame.

## Timing

- Reset values:
  - State = IDLE, so `byte_ready`=1.
  - `confdata`=0, `password`=0, `request`=0, `confirm`=0, `frame_err`=0, `err_count`=0.
  - Staging register, running XOR, index and timeout counter all = 0.
- All outputs are registered.
- Let the checksum byte be accepted in cycle N:
  - `confdata` and `password` take the new values in cycle N+1.
  - `request`=1 in cycle N+1.
  - `confirm`=1 in cycle N+2+`CONFIRM_GAP`.
  - `byte_ready` returns to 1 in cycle N+3+`CONFIRM_GAP`.
- For a bad checksum accepted in cycle N: `frame_err`=1 in cycle N+1, `err_count` is updated in N+1, and `byte_ready` stays 1.
- Timeout: the last byte is accepted in cycle M; `frame_err` is asserted in cycle M+`TIMEOUT`+1.
- `byte_valid` held high while `byte_ready`=0: no byte is consumed, and the source must hold its data.
- `arst` asserted mid-frame or mid-handshake: all state and outputs return to their reset values immediately, without waiting for a clock edge. Any pending `request` or `confirm` is lost.
- `err_count` at 255 stays at 255.

## Test plan

- Good frame A5 01 02 03 04 05 01 → `confdata`=35'h504030201, `password`=0. `request` is high 1 cycle after the checksum byte; `confirm` is high `CONFIRM_GAP`+1 cycles later.
- Same frame with checksum 00 → one `frame_err` pulse, `err_count`=1, `confdata` unchanged, no `request`.
- Frame with P4=8'h20 (reserved bit set) and a correct checksum → rejected, `err_count` increments.
- Frame with P4=8'h18 → `password`=2'b11; `confdata`[34:32]=0.
- Stray 3C 7E before a good frame → both bytes dropped, no error, and the frame loads normally. Then a frame that stalls after P2 for `TIMEOUT` cycles → `frame_err` fires and the block returns to IDLE.
- Assert `arst` during GAP → `confirm` never pulses and all outputs are 0. Then force 256 bad frames → `err_count` holds at 255.
